// File: rtl/wb_fetch_master.sv
// wb_fetch_master
//   Wishbone classic read initiator sitting between the instruction-fetch stage
//   and the memory bus. Accepts one word-fetch request at a time from the core,
//   runs a single CYC_O/STB_O read cycle and returns DAT_I with a one-cycle
//   valid_o pulse. The block only reads, so WE_O is tied low.
//
// Optional feature macro: WB_FETCH_TIMEOUT_EN
//   When defined, a bus cycle that gets no ACK_I within TIMEOUT_CYCLES cycles
//   is abandoned and reported with error_o. When undefined, the bus cycle waits
//   for ACK_I forever and error_o only reports misaligned addresses.
//
// Ports
//   CLK_I    in   clock, rising edge
//   RST_I    in   synchronous active-high reset
//   req_i    in   fetch request, taken when req_i & ready_o
//   addr_i   in   byte address, sampled when the request is taken
//   ready_o  out  block can take a request this cycle
//   valid_o  out  one-cycle pulse, data_o/error_o are meaningful
//   data_o   out  fetched word, held until the next valid_o
//   error_o  out  misaligned or timed-out fetch (qualified by valid_o)
//   CYC_O    out  Wishbone cycle
//   STB_O    out  Wishbone strobe, always equal to CYC_O
//   WE_O     out  Wishbone write enable, constant 0
//   ADR_O    out  latched request address
//   DAT_I    in   read data from the responder
//   ACK_I    in   responder acknowledge

module wb_fetch_master #(
  parameter int ADDR_SIZE      = 32,
  parameter int DATA_SIZE      = 32,
  parameter int OFFSET         = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 req_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 error_o,
  output logic                 CYC_O,
  output logic                 STB_O,
  output logic                 WE_O,
  output logic [ADDR_SIZE-1:0] ADR_O,
  input  logic [DATA_SIZE-1:0] DAT_I,
  input  logic                 ACK_I
);

  typedef enum logic {IDLE, BUS} state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;
  logic                   cyc_q,   cyc_d;
  logic [DATA_SIZE-1:0]   data_q,  data_d;
  logic [ADDR_SIZE-1:0]   adr_q,   adr_d;
  logic                   misaligned;
  logic                   timeout;

  // A word-aligned address has its low OFFSET bits clear; with OFFSET=0 every
  // address is aligned and there are no bits to test.
  generate
    if (OFFSET > 0) begin : g_align
      assign misaligned = |addr_i[OFFSET-1:0];
    end else begin : g_noalign
      assign misaligned = 1'b0;
    end
  endgenerate

`ifdef WB_FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter sits at zero while idle so it is already clear on entry to BUS;
  // it then counts the BUS cycles that ended without an acknowledge.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!ACK_I) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires on the edge that closes the last allowed BUS cycle; an ACK_I on
  // that same edge takes precedence and completes the fetch normally.
  assign timeout = (state_q == BUS) && !ACK_I &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      cyc_q   <= 1'b0;
      data_q  <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      error_q <= error_d;
      cyc_q   <= cyc_d;
      data_q  <= data_d;
      adr_q   <= adr_d;
    end
  end

  // Misaligned requests never leave IDLE; a bus cycle ends on ACK_I or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i && !misaligned) state_d = BUS;
      BUS:     if (ACK_I || timeout)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the output registers. ACK_I in IDLE and req_i in BUS are
  // deliberately not looked at, which keeps both of them harmless.
  always_comb begin
    ready_d = ready_q;
    valid_d = 1'b0;
    error_d = error_q;
    cyc_d   = cyc_q;
    data_d  = data_q;
    adr_d   = adr_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          adr_d = addr_i;
          if (misaligned) begin
            valid_d = 1'b1;
            error_d = 1'b1;
          end else begin
            cyc_d   = 1'b1;
            ready_d = 1'b0;
          end
        end
      end
      BUS: begin
        if (ACK_I) begin
          data_d  = DAT_I;
          error_d = 1'b0;
          valid_d = 1'b1;
          cyc_d   = 1'b0;
          ready_d = 1'b1;
        end else if (timeout) begin
          error_d = 1'b1;
          valid_d = 1'b1;
          cyc_d   = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign error_o = error_q;
  assign data_o  = data_q;
  assign CYC_O   = cyc_q;
  assign STB_O   = cyc_q;
  assign WE_O    = 1'b0;
  assign ADR_O   = adr_q;

endmodule

// File: tb/tb_wb_fetch_master.sv
// tb_wb_fetch_master
//   Self-checking bench for wb_fetch_master: a table of cycle vectors for the
//   basic scenarios, hand sequences for the timeout behaviour, and a random run
//   compared against a transaction-level model of the fetch rules.

module tb_wb_fetch_master;

  localparam int TO = 4;

  typedef struct packed {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] dat;
    logic        expReady;
    logic        expValid;
    logic        expError;
    logic        expCyc;
    logic [31:0] expAdr;
    logic [31:0] expData;
  } vec_t;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        req_i;
  logic [31:0] addr_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        error_o;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic [31:0] ADR_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  int testsRun    = 0;
  int testsFailed = 0;

  vec_t vecs[$];

  // Behavioural model state for the random run.
  bit          mBusy;
  int          mWait;
  logic [31:0] mAdr;
  logic [31:0] mData;

  always #5 CLK_I = ~CLK_I;

  wb_fetch_master #(
    .ADDR_SIZE(32),
    .DATA_SIZE(32),
    .OFFSET(2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .req_i(req_i),
    .addr_i(addr_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o(data_o),
    .error_o(error_o),
    .CYC_O(CYC_O),
    .STB_O(STB_O),
    .WE_O(WE_O),
    .ADR_O(ADR_O),
    .DAT_I(DAT_I),
    .ACK_I(ACK_I)
  );

  function automatic vec_t mkVec(input logic rst, input logic req, input logic [31:0] addr,
                                 input logic ack, input logic [31:0] dat,
                                 input logic eReady, input logic eValid, input logic eErr,
                                 input logic eCyc, input logic [31:0] eAdr,
                                 input logic [31:0] eData);
    vec_t v;
    v.rst = rst; v.req = req; v.addr = addr; v.ack = ack; v.dat = dat;
    v.expReady = eReady; v.expValid = eValid; v.expError = eErr;
    v.expCyc = eCyc; v.expAdr = eAdr; v.expData = eData;
    return v;
  endfunction

  // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit later.
  task automatic applyStimulus(input logic rst, input logic req, input logic [31:0] addr,
                               input logic ack, input logic [31:0] dat);
    RST_I  = rst;
    req_i  = req;
    addr_i = addr;
    ACK_I  = ack;
    DAT_I  = dat;
    @(posedge CLK_I);
    #1;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // error_o is only meaningful alongside valid_o, so it is compared only then.
  task automatic checkOutput(input string tag, input logic eReady, input logic eValid,
                             input logic eErr, input logic eCyc, input logic [31:0] eAdr,
                             input logic [31:0] eData);
    checkField({tag, ".ready"}, {31'b0, ready_o}, {31'b0, eReady});
    checkField({tag, ".valid"}, {31'b0, valid_o}, {31'b0, eValid});
    if (eValid) checkField({tag, ".error"}, {31'b0, error_o}, {31'b0, eErr});
    checkField({tag, ".cyc"},   {31'b0, CYC_O},   {31'b0, eCyc});
    checkField({tag, ".stb"},   {31'b0, STB_O},   {31'b0, eCyc});
    checkField({tag, ".we"},    {31'b0, WE_O},    32'h0);
    checkField({tag, ".adr"},   ADR_O,            eAdr);
    checkField({tag, ".data"},  data_o,           eData);
  endtask

  initial begin
    logic        rRst, rReq, rAck, eValid, eErr;
    logic [31:0] rAddr, rDat;

    // Reset, aligned fetch with 3-cycle ACK, misaligned fetch, back-to-back
    // fetches, ignored ACK in IDLE, reset in BUS with late ACK, reset priority.
    vecs.push_back(mkVec(1, 0, 32'h00, 0, 32'h0,        1, 0, 0, 0, 32'h00, 32'h0));
    vecs.push_back(mkVec(1, 0, 32'h00, 0, 32'h0,        1, 0, 0, 0, 32'h00, 32'h0));
    vecs.push_back(mkVec(0, 1, 32'h10, 0, 32'h0,        0, 0, 0, 1, 32'h10, 32'h0));
    vecs.push_back(mkVec(0, 0, 32'h00, 0, 32'h0,        0, 0, 0, 1, 32'h10, 32'h0));
    vecs.push_back(mkVec(0, 0, 32'h00, 0, 32'h0,        0, 0, 0, 1, 32'h10, 32'h0));
    vecs.push_back(mkVec(0, 0, 32'h00, 1, 32'hDEADBEEF, 1, 1, 0, 0, 32'h10, 32'hDEADBEEF));
    vecs.push_back(mkVec(0, 0, 32'h00, 0, 32'h0,        1, 0, 0, 0, 32'h10, 32'hDEADBEEF));
    vecs.push_back(mkVec(0, 1, 32'h13, 0, 32'h0,        1, 1, 1, 0, 32'h13, 32'hDEADBEEF));
    vecs.push_back(mkVec(0, 0, 32'h00, 0, 32'h0,        1, 0, 0, 0, 32'h13, 32'hDEADBEEF));
    vecs.push_back(mkVec(0, 1, 32'h00, 0, 32'h0,        0, 0, 0, 1, 32'h00, 32'hDEADBEEF));
    vecs.push_back(mkVec(0, 1, 32'h04, 1, 32'h11111111, 1, 1, 0, 0, 32'h00, 32'h11111111));
    vecs.push_back(mkVec(0, 1, 32'h04, 0, 32'h0,        0, 0, 0, 1, 32'h04, 32'h11111111));
    vecs.push_back(mkVec(0, 0, 32'h00, 1, 32'h22222222, 1, 1, 0, 0, 32'h04, 32'h22222222));
    vecs.push_back(mkVec(0, 0, 32'h00, 0, 32'h0,        1, 0, 0, 0, 32'h04, 32'h22222222));
    vecs.push_back(mkVec(0, 0, 32'h00, 1, 32'h33333333, 1, 0, 0, 0, 32'h04, 32'h22222222));
    vecs.push_back(mkVec(0, 1, 32'h20, 0, 32'h0,        0, 0, 0, 1, 32'h20, 32'h22222222));
    vecs.push_back(mkVec(1, 0, 32'h00, 0, 32'h0,        1, 0, 0, 0, 32'h00, 32'h0));
    vecs.push_back(mkVec(0, 0, 32'h00, 1, 32'h44,       1, 0, 0, 0, 32'h00, 32'h0));
    vecs.push_back(mkVec(1, 1, 32'h40, 1, 32'h55,       1, 0, 0, 0, 32'h00, 32'h0));
    vecs.push_back(mkVec(0, 0, 32'h00, 0, 32'h0,        1, 0, 0, 0, 32'h00, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].addr, vecs[i].ack, vecs[i].dat);
      checkOutput($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expValid,
                  vecs[i].expError, vecs[i].expCyc, vecs[i].expAdr, vecs[i].expData);
    end

    // Unanswered bus cycle.
    applyStimulus(0, 1, 32'h80, 0, 32'h0);
    checkOutput("stall.start", 0, 0, 0, 1, 32'h80, 32'h0);
`ifdef WB_FETCH_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      applyStimulus(0, 0, 32'h0, 0, 32'h0);
      checkOutput($sformatf("timeout.wait%0d", i), 0, 0, 0, 1, 32'h80, 32'h0);
    end
    applyStimulus(0, 0, 32'h0, 0, 32'h0);
    checkOutput("timeout.expire", 1, 1, 1, 0, 32'h80, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0);
    checkOutput("timeout.after", 1, 0, 0, 0, 32'h80, 32'h0);

    // ACK on the final count edge completes normally.
    applyStimulus(0, 1, 32'h84, 0, 32'h0);
    checkOutput("lastack.start", 0, 0, 0, 1, 32'h84, 32'h0);
    for (int i = 1; i < TO; i++) begin
      applyStimulus(0, 0, 32'h0, 0, 32'h0);
      checkOutput($sformatf("lastack.wait%0d", i), 0, 0, 0, 1, 32'h84, 32'h0);
    end
    applyStimulus(0, 0, 32'h0, 1, 32'h0000ABCD);
    checkOutput("lastack.done", 1, 1, 0, 0, 32'h84, 32'h0000ABCD);
`else
    for (int i = 1; i <= 50; i++) begin
      applyStimulus(0, 0, 32'h0, 0, 32'h0);
      checkOutput($sformatf("stall.wait%0d", i), 0, 0, 0, 1, 32'h80, 32'h0);
    end
    applyStimulus(0, 0, 32'h0, 1, 32'h0000ABCD);
    checkOutput("stall.done", 1, 1, 0, 0, 32'h80, 32'h0000ABCD);
`endif

    // Random run against the fetch-rule model.
    applyStimulus(1, 0, 32'h0, 0, 32'h0);
    mBusy = 0; mWait = 0; mAdr = 32'h0; mData = 32'h0;
    checkOutput("rand.reset", 1, 0, 0, 0, 32'h0, 32'h0);
    for (int c = 0; c < 400; c++) begin
      rRst  = ($urandom_range(0, 59) == 0);
      rReq  = ($urandom_range(0, 1) == 1);
      rAddr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rAddr = rAddr + 32'($urandom_range(1, 3));
      rAck  = mBusy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      rDat  = $urandom;
      eValid = 1'b0;
      eErr   = 1'b0;
      if (rRst) begin
        mBusy = 0; mWait = 0; mAdr = 32'h0; mData = 32'h0;
      end else if (!mBusy) begin
        if (rReq) begin
          mAdr = rAddr;
          if (rAddr % 4 != 0) begin
            eValid = 1'b1;
            eErr   = 1'b1;
          end else begin
            mBusy = 1;
            mWait = 0;
          end
        end
      end else if (rAck) begin
        mData  = rDat;
        eValid = 1'b1;
        mBusy  = 0;
      end else begin
        mWait++;
`ifdef WB_FETCH_TIMEOUT_EN
        if (mWait == TO) begin
          eValid = 1'b1;
          eErr   = 1'b1;
          mBusy  = 0;
        end
`endif
      end
      applyStimulus(rRst, rReq, rAddr, rAck, rDat);
      checkOutput($sformatf("rand%0d", c), !mBusy, eValid, eErr, mBusy, mAdr, mData);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
